// File: rtl/fir_convolve_pkg.sv
// fir_convolve_pkg: shared FSM states, sizing helpers and output saturation for the FIR convolver
package fir_convolve_pkg;
  typedef enum logic [2:0] {CLEAR, WAIT_IMPULSE, IDLE, WRITE, MAC, REDUCE, DONE} state_t;
  function automatic int depth(input int taps, input int lanes);
    return taps / lanes;
  endfunction
  function automatic int latency(input int taps, input int lanes);
    return taps / lanes + lanes + 5;
  endfunction
  function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int shift, input int w);
    logic signed [127:0] r, hi, lo;
    r = (v + (128'sd1 <<< (shift - 1))) >>> shift;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/fir_history_banks.sv
// fir_history_banks: circular audio history in LANES banks, read back lane-aligned two cycles after beat
module fir_history_banks
  import fir_convolve_pkg::*;
#(
  parameter int TAPS = 24000,
  parameter int LANES = 8,
  parameter int SAMPLE_W = 16,
  localparam int PW = $clog2(TAPS),
  localparam int AW = $clog2(TAPS / LANES)
) (
  input  logic                         audio_clk,
  input  logic [PW-1:0]                wp,
  input  logic [AW-1:0]                beat,
  input  logic                         we,
  input  logic [SAMPLE_W-1:0]          wdata,
  input  logic                         clr,
  input  logic [AW-1:0]                clr_row,
  output logic [LANES*SAMPLE_W-1:0]    lanes
);
  localparam int DEPTH = depth(TAPS, LANES);
  localparam int LB = $clog2(LANES);
  logic [AW-1:0] wr, r0, r1;
  logic [LB-1:0] wb;
  logic [SAMPLE_W-1:0] bank_q [LANES];
  assign wr = wp[PW-1:LB];
  assign wb = wp[LB-1:0];
  assign r0 = wr - beat + (wr >= beat ? '0 : AW'(DEPTH));
  assign r1 = r0 == '0 ? AW'(DEPTH - 1) : r0 - 1'b1;
  for (genvar k = 0; k < LANES; k++) begin : g_bank
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] q;
    // banks above the write bank hold the newest row one step behind
    always_ff @(posedge audio_clk) begin
      if (clr) mem[clr_row] <= '0;
      else if (we && wb == LB'(k)) mem[wr] <= wdata;
      q <= mem[LB'(k) > wb ? r1 : r0];
    end
    assign bank_q[k] = q;
  end
  always_ff @(posedge audio_clk) begin
    for (int l = 0; l < LANES; l++) lanes[l*SAMPLE_W +: SAMPLE_W] <= bank_q[wb - LB'(l)];
  end
endmodule

// File: rtl/fir_convolve_engine.sv
// fir_convolve_engine: lane-parallel direct-form FIR, LANES taps per clock, rounded and saturated output
module fir_convolve_engine
  import fir_convolve_pkg::*;
#(
  parameter int TAPS = 24000,
  parameter int LANES = 8,
  parameter int SAMPLE_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W = 48,
  parameter int OUT_SHIFT = 15,
  parameter int OUT_W = 16,
  localparam int AW = $clog2(TAPS / LANES)
) (
  input  logic                        audio_clk,
  input  logic                        rst_in,
  input  logic                        impulse_ready,
  input  logic                        clear_history,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic signed [SAMPLE_W-1:0]  sample_in,
  output logic [AW-1:0]               coef_addr,
  input  logic [LANES*COEF_W-1:0]     coef_vals,
  output logic                        result_valid,
  output logic signed [ACC_W-1:0]     result_acc,
  output logic signed [OUT_W-1:0]     result_sat,
  output logic                        overrun,
  output logic                        busy
);
  localparam int DEPTH = depth(TAPS, LANES);
  localparam int LATENCY = latency(TAPS, LANES);
  localparam int PW = $clog2(TAPS);
  localparam int LB = $clog2(LANES);
  localparam int CW = $clog2(DEPTH + LANES + 2);
  localparam int PRW = SAMPLE_W + COEF_W;
  state_t state;
  logic [PW-1:0] wp;
  logic [CW-1:0] cnt;
  logic [SAMPLE_W-1:0] x_lat;
  logic v1, v2;
  logic [LANES*SAMPLE_W-1:0] lanes;
  logic signed [ACC_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0] part [LANES];
  logic signed [ACC_W-1:0] acc;
  assign sample_ready = state == IDLE;
  assign busy = state != IDLE;
  fir_history_banks #(.TAPS(TAPS), .LANES(LANES), .SAMPLE_W(SAMPLE_W)) u_hist (
    .audio_clk(audio_clk),
    .wp(wp),
    .beat(coef_addr),
    .we(state == WRITE),
    .wdata(x_lat),
    .clr(state == CLEAR),
    .clr_row(cnt[AW-1:0]),
    .lanes(lanes)
  );
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PRW-1:0] p;
    assign p = $signed(lanes[l*SAMPLE_W +: SAMPLE_W]) * $signed(coef_vals[l*COEF_W +: COEF_W]);
    assign prod[l] = ACC_W'(p);
  end
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state <= CLEAR;
      wp <= '0;
      cnt <= '0;
      overrun <= 1'b0;
      result_valid <= 1'b0;
      result_acc <= '0;
      result_sat <= '0;
      coef_addr <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      v1 <= state == MAC && cnt < CW'(DEPTH);
      v2 <= v1;
      if (v2) for (int l = 0; l < LANES; l++) part[l] <= part[l] + prod[l];
      if (clear_history) begin
        state <= CLEAR;
        cnt <= '0;
        overrun <= 1'b0;
      end else begin
        if (sample_valid && state != IDLE) overrun <= 1'b1;
        case (state)
          CLEAR: begin
            cnt <= cnt == CW'(DEPTH - 1) ? '0 : cnt + 1'b1;
            if (cnt == CW'(DEPTH - 1)) state <= WAIT_IMPULSE;
          end
          WAIT_IMPULSE: if (impulse_ready) state <= IDLE;
          IDLE: begin
            if (sample_valid) begin
              x_lat <= sample_in;
              state <= WRITE;
            end else if (!impulse_ready) state <= WAIT_IMPULSE;
          end
          WRITE: begin
            state <= MAC;
            cnt <= '0;
            coef_addr <= '0;
            acc <= '0;
            for (int l = 0; l < LANES; l++) part[l] <= '0;
          end
          MAC: begin
            cnt <= cnt + 1'b1;
            if (cnt < CW'(DEPTH - 1)) coef_addr <= coef_addr + 1'b1;
            if (cnt == CW'(DEPTH + 1)) begin
              state <= REDUCE;
              cnt <= '0;
            end
          end
          REDUCE: begin
            acc <= acc + part[cnt[LB-1:0]];
            cnt <= cnt + 1'b1;
            if (cnt == CW'(LATENCY - DEPTH - 6)) state <= DONE;
          end
          DONE: begin
            result_valid <= 1'b1;
            result_acc <= acc;
            result_sat <= OUT_W'(saturate(128'(acc), OUT_SHIFT, OUT_W));
            wp <= wp == PW'(TAPS - 1) ? '0 : wp + 1'b1;
            state <= IDLE;
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fir_convolve_engine.sv
// tb_fir_convolve_engine: directed checks of the FIR engine at TAPS=16, LANES=4
module tb_fir_convolve_engine;
  localparam int TAPS = 16;
  localparam int LANES = 4;
  localparam int D = 4;
  localparam int LAT = 13;
  localparam int AW = 2;
  logic audio_clk = 1'b0;
  logic rst_in, impulse_ready, clear_history, sample_valid, sample_ready;
  logic result_valid, overrun, busy;
  logic signed [15:0] sample_in, result_sat;
  logic [AW-1:0] coef_addr, a1, a2;
  logic [63:0] coef_vals;
  logic signed [47:0] result_acc;
  int compared = 0;
  int mismatched = 0;
  int h [TAPS];
  longint xs [TAPS];
  int wpm = 0;
  always #5 audio_clk = ~audio_clk;
  fir_convolve_engine #(.TAPS(TAPS), .LANES(LANES)) dut (
    .audio_clk(audio_clk),
    .rst_in(rst_in),
    .impulse_ready(impulse_ready),
    .clear_history(clear_history),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_in(sample_in),
    .coef_addr(coef_addr),
    .coef_vals(coef_vals),
    .result_valid(result_valid),
    .result_acc(result_acc),
    .result_sat(result_sat),
    .overrun(overrun),
    .busy(busy)
  );
  always @(posedge audio_clk) begin
    a1 <= coef_addr;
    a2 <= a1;
  end
  always_comb begin
    coef_vals = '0;
    for (int l = 0; l < LANES; l++) coef_vals[l*16 +: 16] = 16'(h[int'(a2) * LANES + l]);
  end
  function automatic longint model_push(input int x);
    longint y = 0;
    xs[wpm] = x;
    for (int k = 0; k < TAPS; k++) y += longint'(h[k]) * xs[(wpm - k + TAPS) % TAPS];
    wpm = (wpm + 1) % TAPS;
    return y;
  endfunction
  function automatic longint sat_m(input longint y);
    longint r = (y + 16384) >>> 15;
    return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
  endfunction
  task automatic send(input int x, input int poke, output longint acc, output longint sat, output int lat);
    int n = 0;
    while (!sample_ready && n < 200) begin
      @(negedge audio_clk);
      n++;
    end
    if (!sample_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout sample_ready=%0b required 1", sample_ready);
    end
    sample_in = 16'(x);
    sample_valid = 1'b1;
    @(negedge audio_clk);
    sample_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 200) begin
      sample_valid = lat == poke;
      sample_in = 16'sd777;
      @(negedge audio_clk);
      lat++;
    end
    sample_valid = 1'b0;
    if (!result_valid) begin
      compared++;
      mismatched++;
      $display("FAIL result_timeout result_valid=%0b required 1", result_valid);
    end
    acc = longint'(result_acc);
    sat = longint'(result_sat);
  endtask
  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) xs[k] = 0;
  endtask
  task automatic test_reset();
    int n = 0;
    compared++;
    if ({sample_ready, result_valid, overrun, busy} !== 4'b0001) begin
      mismatched++;
      $display("FAIL reset_flags got %b required 0001", {sample_ready, result_valid, overrun, busy});
    end
    compared++;
    if (result_acc !== 48'sd0 || result_sat !== 16'sd0 || coef_addr !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_outputs acc=%0d sat=%0d addr=%0d required 0", result_acc, result_sat, coef_addr);
    end
    rst_in = 1'b0;
    while (!sample_ready && n < 50) begin
      n++;
      @(negedge audio_clk);
    end
    compared++;
    if (n !== D + 1) begin
      mismatched++;
      $display("FAIL reset_clear_len got %0d required %0d", n, D + 1);
    end
  endtask
  task automatic test_identity();
    int xv [3] = '{1000, -2000, 32767};
    longint ea [3] = '{32767000, -65534000, 1073676289};
    longint es [3] = '{1000, -2000, 32766};
    longint acc, sat;
    int lat;
    h[0] = 32767;
    for (int i = 0; i < 3; i++) begin
      send(xv[i], 0, acc, sat, lat);
      void'(model_push(xv[i]));
      compared++;
      if (acc !== ea[i] || sat !== es[i]) begin
        mismatched++;
        $display("FAIL identity[%0d] acc=%0d sat=%0d required %0d %0d", i, acc, sat, ea[i], es[i]);
      end
      compared++;
      if (lat !== LAT) begin
        mismatched++;
        $display("FAIL identity_latency[%0d] got %0d required %0d", i, lat, LAT);
      end
    end
  endtask
  task automatic test_impulse_drop();
    impulse_ready = 1'b0;
    @(negedge audio_clk);
    compared++;
    if (sample_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL impulse_drop ready=%0b busy=%0b required 0 1", sample_ready, busy);
    end
    impulse_ready = 1'b1;
    @(negedge audio_clk);
    compared++;
    if (sample_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL impulse_return ready=%0b required 1", sample_ready);
    end
  endtask
  task automatic pulse_clear();
    clear_history = 1'b1;
    @(negedge audio_clk);
    clear_history = 1'b0;
    clear_model();
  endtask
  task automatic test_delay();
    longint acc, sat, ea;
    int lat;
    for (int k = 0; k < TAPS; k++) h[k] = 0;
    h[5] = 1;
    pulse_clear();
    for (int n = 0; n < 40; n++) begin
      send(n + 1, 0, acc, sat, lat);
      void'(model_push(n + 1));
      ea = n >= 5 ? n - 4 : 0;
      compared++;
      if (acc !== ea || sat !== 0) begin
        mismatched++;
        $display("FAIL delay[%0d] acc=%0d sat=%0d required %0d 0", n, acc, sat, ea);
      end
    end
  endtask
  task automatic test_full_scale();
    longint acc, sat;
    int lat;
    for (int k = 0; k < TAPS; k++) h[k] = 32767;
    pulse_clear();
    for (int n = 0; n < TAPS; n++) send(32767, 0, acc, sat, lat);
    compared++;
    if (acc !== 64'sd17178820624 || sat !== 32767) begin
      mismatched++;
      $display("FAIL full_pos acc=%0d sat=%0d required 17178820624 32767", acc, sat);
    end
    for (int n = 0; n < TAPS; n++) send(-32768, 0, acc, sat, lat);
    compared++;
    if (acc !== -64'sd17179344896 || sat !== -32768) begin
      mismatched++;
      $display("FAIL full_neg acc=%0d sat=%0d required -17179344896 -32768", acc, sat);
    end
    for (int k = 0; k < TAPS; k++) xs[k] = -32768;
  endtask
  task automatic test_random();
    longint acc, sat, ey;
    int lat, x;
    for (int k = 0; k < TAPS; k++) h[k] = int'($urandom_range(65535)) - 32768;
    for (int n = 0; n < 50; n++) begin
      x = int'($urandom_range(65535)) - 32768;
      send(x, 0, acc, sat, lat);
      ey = model_push(x);
      compared++;
      if (acc !== ey || sat !== sat_m(ey)) begin
        mismatched++;
        $display("FAIL random[%0d] acc=%0d sat=%0d required %0d %0d", n, acc, sat, ey, sat_m(ey));
      end
    end
  endtask
  task automatic test_overrun_clear();
    longint acc, sat, ey;
    int lat, n = 0;
    send(100, 4, acc, sat, lat);
    ey = model_push(100);
    compared++;
    if (acc !== ey || overrun !== 1'b1) begin
      mismatched++;
      $display("FAIL overrun_sample acc=%0d ovr=%0b required %0d 1", acc, overrun, ey);
    end
    send(200, 0, acc, sat, lat);
    ey = model_push(200);
    compared++;
    if (acc !== ey || sat !== sat_m(ey)) begin
      mismatched++;
      $display("FAIL overrun_next acc=%0d sat=%0d required %0d %0d", acc, sat, ey, sat_m(ey));
    end
    sample_valid = 1'b1;
    sample_in = 16'sd5000;
    clear_history = 1'b1;
    @(negedge audio_clk);
    sample_valid = 1'b0;
    clear_history = 1'b0;
    clear_model();
    compared++;
    if (overrun !== 1'b0 || sample_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_flags ovr=%0b ready=%0b required 0 0", overrun, sample_ready);
    end
    while (!sample_ready && n < 50) begin
      n++;
      @(negedge audio_clk);
    end
    compared++;
    if (n !== D + 1) begin
      mismatched++;
      $display("FAIL clear_len got %0d required %0d", n, D + 1);
    end
    for (int i = 0; i < 3; i++) begin
      send(300 * (i + 1), 0, acc, sat, lat);
      ey = model_push(300 * (i + 1));
      compared++;
      if (acc !== ey || sat !== sat_m(ey)) begin
        mismatched++;
        $display("FAIL after_clear[%0d] acc=%0d sat=%0d required %0d %0d", i, acc, sat, ey, sat_m(ey));
      end
    end
  endtask
  task automatic test_reset_mid_mac();
    longint acc, sat, ey;
    int lat, n = 0;
    bit saw = 1'b0;
    sample_in = 16'sd1234;
    sample_valid = 1'b1;
    @(negedge audio_clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge audio_clk);
    rst_in = 1'b1;
    @(negedge audio_clk);
    rst_in = 1'b0;
    clear_model();
    wpm = 0;
    compared++;
    if (result_acc !== 48'sd0 || result_sat !== 16'sd0 || overrun !== 1'b0 || coef_addr !== 2'd0) begin
      mismatched++;
      $display("FAIL midreset_outputs acc=%0d sat=%0d ovr=%0b addr=%0d required 0", result_acc, result_sat, overrun, coef_addr);
    end
    for (int i = 0; i < LAT + 5; i++) begin
      if (result_valid) saw = 1'b1;
      if (!sample_ready && i == n) n++;
      @(negedge audio_clk);
    end
    compared++;
    if (saw !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_valid got %0b required 0", saw);
    end
    compared++;
    if (n !== D + 1) begin
      mismatched++;
      $display("FAIL midreset_clear_len got %0d required %0d", n, D + 1);
    end
    send(-777, 0, acc, sat, lat);
    ey = model_push(-777);
    compared++;
    if (acc !== ey || sat !== sat_m(ey) || lat !== LAT) begin
      mismatched++;
      $display("FAIL midreset_resume acc=%0d sat=%0d lat=%0d required %0d %0d %0d", acc, sat, lat, ey, sat_m(ey), LAT);
    end
  endtask
  initial begin
    rst_in = 1'b1;
    impulse_ready = 1'b1;
    clear_history = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    for (int k = 0; k < TAPS; k++) h[k] = 0;
    clear_model();
    repeat (3) @(negedge audio_clk);
    test_reset();
    test_identity();
    test_impulse_drop();
    test_delay();
    test_full_scale();
    test_random();
    test_overrun_clear();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
